// File: rtl/systolic_run_sequencer.sv
// systolic_run_sequencer
// Self-contained host engine for one systolic_top workload.
// It streams channel-tagged write commands into the array's host memory ports,
// pulses ap_start, and waits for ap_done under a watchdog. It then reads back
// chk_count output words and compares them against a streamed expected vector.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_*               write command stream (valid/ready); cmd_last closes the
//                       load phase and samples chk_count
//   mem_en/addr/data    one-hot registered write strobe to NUM_CH memories
//   ap_start, ap_done   run handshake with the array
//   addrO, dataO        output memory read port (RD_LATENCY cycles)
//   exp_*               expected-word stream (valid/ready)
//   busy, done, pass, timeout, err_count, first_err_addr   run status/result
module systolic_run_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int RESULT_WIDTH   = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int NUM_CH         = 3,
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 200000,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CH_W-1:0]         cmd_ch,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic                    cmd_last,
  input  logic [ADDR_WIDTH:0]     chk_count,
  output logic [NUM_CH-1:0]       mem_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data,
  output logic                    ap_start,
  input  logic                    ap_done,
  output logic [ADDR_WIDTH-1:0]   addrO,
  input  logic [RESULT_WIDTH-1:0] dataO,
  input  logic                    exp_valid,
  output logic                    exp_ready,
  input  logic [RESULT_WIDTH-1:0] exp_data,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LAUNCH, S_START, S_WAIT_DONE,
    S_RD_ISSUE, S_RD_WAIT, S_COMPARE, S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   chk_q;
  logic [WD_W-1:0]       wd_cnt;
  logic [2:0]            lat_cnt;
  logic                  cmd_hs;
  logic                  wd_tc;
  logic                  rd_last;
  logic                  mismatch;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == CH_W'(c)) v[c] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign cmd_hs   = cmd_valid && cmd_ready;
  assign wd_tc    = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign rd_last  = (({1'b0, addrO} + (ADDR_WIDTH + 1)'(1)) == chk_q);
  assign mismatch = (dataO != exp_data);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    ap_start  = 1'b0;
    exp_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE, S_LOAD, S_DONE: begin
        cmd_ready = 1'b1;
        busy      = (state == S_LOAD);
        done      = (state == S_DONE);
        if (cmd_hs) state_nxt = cmd_last ? S_LAUNCH : S_LOAD;
      end
      // LAUNCH lets the final write strobe retire before ap_start
      S_LAUNCH:    state_nxt = S_START;
      S_START: begin
        ap_start  = 1'b1;
        state_nxt = S_WAIT_DONE;
      end
      // ap_done takes priority over the watchdog terminal count
      S_WAIT_DONE: begin
        if (ap_done)    state_nxt = (chk_q == '0) ? S_DONE : S_RD_ISSUE;
        else if (wd_tc) state_nxt = S_DONE;
      end
      S_RD_ISSUE:  state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (lat_cnt == 3'(RD_LATENCY - 1)) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        exp_ready = 1'b1;
        if (exp_valid) state_nxt = rd_last ? S_DONE : S_RD_ISSUE;
      end
      default:     state_nxt = S_IDLE;
    endcase
    pass = done && (err_count == 16'd0) && !timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      mem_en         <= '0;
      mem_addr       <= '0;
      mem_data       <= '0;
      chk_q          <= '0;
      wd_cnt         <= '0;
      lat_cnt        <= '0;
      addrO          <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else begin
      state <= state_nxt;

      // write strobe stage: one registered cycle per accepted command
      mem_en <= cmd_hs ? ch_onehot(cmd_ch) : '0;
      if (cmd_hs) begin
        mem_addr <= cmd_addr;
        mem_data <= cmd_data;
      end
      if (cmd_hs && cmd_last) chk_q <= chk_count;
      if (cmd_hs && state == S_DONE) begin
        err_count      <= '0;
        first_err_addr <= '0;
        timeout        <= 1'b0;
      end

      // watchdog stage
      wd_cnt <= (state == S_WAIT_DONE) ? wd_cnt + 1'b1 : '0;
      if (state == S_WAIT_DONE && !ap_done && wd_tc) timeout <= 1'b1;

      // readback stage: addrO doubles as the word index
      lat_cnt <= (state == S_RD_WAIT) ? lat_cnt + 3'd1 : 3'd0;
      if (state == S_WAIT_DONE && ap_done) addrO <= '0;
      if (state == S_COMPARE && exp_valid) begin
        if (!rd_last) addrO <= addrO + 1'b1;
        if (mismatch) begin
          err_count <= sat_inc16(err_count);
          if (err_count == 16'd0) first_err_addr <= addrO;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_run_sequencer.sv
module tb_systolic_run_sequencer;

  logic        clk = 0;
  logic        rst = 1;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [1:0]  cmd_ch = 0;
  logic [9:0]  cmd_addr = 0;
  logic [15:0] cmd_data = 0;
  logic        cmd_last = 0;
  logic [10:0] chk_count = 0;
  logic [2:0]  mem_en;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data;
  logic        ap_start;
  logic        ap_done;
  logic [9:0]  addrO;
  logic [15:0] dataO = 0;
  logic        exp_valid;
  logic        exp_ready;
  logic [15:0] exp_data;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [9:0]  first_err_addr;

  systolic_run_sequencer #(
    .DATA_WIDTH(16), .RESULT_WIDTH(16), .ADDR_WIDTH(10), .NUM_CH(3),
    .RD_LATENCY(1), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_last(cmd_last),
    .chk_count(chk_count),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .ap_start(ap_start), .ap_done(ap_done),
    .addrO(addrO), .dataO(dataO),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  en;
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] err;
    logic [9:0]  first;
    logic        pass;
    logic        to;
    int          lat;
  } res_t;

  wr_t         wr_q[$];
  int          start_q[$];
  logic [9:0]  addr_q[$];
  res_t        res_q[$];
  logic [15:0] exp_src_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int exp_rdy_cnt = 0;
  int res_cnt = 0;
  int start_cyc = 0;
  int done_delay = 50;
  logic stall_mode = 0;
  logic [15:0] omem [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  // output memory with one cycle of read latency
  always @(posedge clk) dataO <= omem[addrO[3:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // array model: raises ap_done done_delay cycles after ap_start (-1 = never)
  initial begin : resp
    int cnt;
    cnt = -1;
    ap_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin ap_done = 0; cnt = -1; end
      else if (ap_start) begin ap_done = 0; cnt = done_delay; end
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) ap_done = 1;
      end
    end
  end

  // expected-word source, optionally valid every other cycle
  initial begin : src
    logic phase;
    phase = 0;
    exp_valid = 0;
    exp_data = 0;
    forever begin
      @(negedge clk);
      phase = !phase;
      if (exp_src_q.size() > 0 && (!stall_mode || phase)) begin
        exp_valid = 1;
        exp_data = exp_src_q[0];
        if (exp_ready && !rst) void'(exp_src_q.pop_front());
      end else begin
        exp_valid = 0;
      end
    end
  end

  // monitor: pops scoreboard queues whenever the DUT presents something
  initial begin : mon
    wr_t  w;
    res_t r;
    logic done_prev;
    done_prev = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        done_prev = 0;
        continue;
      end
      if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
        w = wr_q.pop_front();
        check("mem_en", mem_en, w.en);
        if (w.en != 0) begin
          check("mem_addr", mem_addr, w.addr);
          check("mem_data", mem_data, w.data);
          strobe_cnt++;
        end
      end else if (mem_en != 0) begin
        check("unexpected_strobe", mem_en, 0);
      end
      if (ap_start) begin
        start_cyc = cyc;
        check("ap_start_no_overlap", mem_en, 0);
        if (start_q.size() > 0) check("ap_start_cycle", cyc, start_q.pop_front());
        else check("unexpected_ap_start", ap_start, 0);
      end
      if (exp_ready) exp_rdy_cnt++;
      if (exp_valid && exp_ready) begin
        if (addr_q.size() > 0) check("addrO", addrO, addr_q.pop_front());
        else check("unexpected_exp_hs", exp_ready, 0);
      end
      if (done && !done_prev) begin
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          check("err_count", err_count, r.err);
          check("first_err_addr", first_err_addr, r.first);
          check("pass", pass, r.pass);
          check("timeout", timeout, r.to);
          if (r.lat >= 0) check("done_latency", cyc - start_cyc, r.lat);
        end else begin
          check("unexpected_done", done, 0);
        end
        res_cnt++;
      end
      done_prev = done;
    end
  end

  task automatic send_cmd(input logic [1:0] ch, input logic [9:0] a, input logic [15:0] d,
                          input logic last, input logic [10:0] cc);
    wr_t w;
    int guard;
    @(negedge clk);
    cmd_valid = 1; cmd_ch = ch; cmd_addr = a; cmd_data = d; cmd_last = last; chk_count = cc;
    guard = 0;
    while (!cmd_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_wait", cmd_ready, 1);
      return;
    end
    w.cyc = cyc + 1;
    w.en = (ch < 3) ? (3'b001 << ch) : 3'b000;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
    if (last) start_q.push_back(cyc + 2);
  endtask

  task automatic end_cmds();
    @(negedge clk);
    cmd_valid = 0;
    cmd_last = 0;
  endtask

  // kind: 0 = 4x4 load, 1 = 4x4 load with a cmd_ch=3 command, 2 = short 3-word load
  task automatic do_load(input int kind, input logic [10:0] cc);
    if (kind == 2) begin
      for (int i = 0; i < 3; i++)
        send_cmd(2'(i), 10'(i), 16'h0C00 + 16'(i), (i == 2), cc);
    end else begin
      for (int i = 0; i < 16; i++) send_cmd(2'd0, 10'(i), 16'h0A00 + 16'(i), 1'b0, 11'd0);
      if (kind == 1) send_cmd(2'd3, 10'h3FF, 16'hDEAD, 1'b0, 11'd0);
      for (int i = 0; i < 16; i++) send_cmd(2'd1, 10'(i), 16'h0B00 + 16'(i), 1'b0, 11'd0);
      send_cmd(2'd2, 10'd0, 16'd4, 1'b0, 11'd0);
      send_cmd(2'd2, 10'd1, 16'd0, 1'b1, cc);
    end
    end_cmds();
  endtask

  task automatic run(input int n, input logic [15:0] corrupt, input int delay,
                     input logic stall, input int kind, input int lat);
    res_t r;
    int base, guard;
    logic to;
    to = (delay < 0);
    done_delay = delay;
    stall_mode = stall;
    r.err = 0;
    r.first = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (corrupt[i]) begin
        r.err++;
        r.first = 10'(i);
      end
    end
    if (to) begin
      r.err = 0;
      r.first = 0;
    end
    r.to = to;
    r.pass = (r.err == 0) && !to;
    r.lat = lat;
    if (!to) begin
      for (int i = 0; i < n; i++) begin
        addr_q.push_back(10'(i));
        exp_src_q.push_back(corrupt[i] ? (omem[i] ^ 16'h0040) : omem[i]);
      end
    end
    res_q.push_back(r);
    base = res_cnt;
    do_load(kind, 11'(n));
    guard = 0;
    while (res_cnt == base && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (res_cnt == base) check("done_wait", done, 1);
    @(negedge clk);
  endtask

  initial begin : guard_timer
    #2000000;
    $display("FAIL global_time_limit: actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin : main
    for (int i = 0; i < 16; i++) omem[i] = 16'h1000 + 16'(i * 16'h0111);

    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_ap_start", ap_start, 0);
    check("rst_exp_ready", exp_ready, 0);
    check("rst_pass", pass, 0);
    @(negedge clk);
    rst = 0;

    // clean 4x4 run: 34 strobes, 16 words compared
    strobe_cnt = 0;
    run(16, 16'h0000, 50, 0, 0, 50 + 1 + 3 * 16);
    check("strobe_count_4x4", strobe_cnt, 34);

    // words 3 and 9 corrupted
    run(16, 16'h0208, 50, 0, 0, 50 + 1 + 3 * 16);

    // ap_done never arrives
    exp_rdy_cnt = 0;
    run(16, 16'h0000, -1, 0, 0, 101);
    check("exp_ready_never", exp_rdy_cnt, 0);

    // stalled expected stream with a non-existent channel in the load
    strobe_cnt = 0;
    run(16, 16'h0000, 50, 1, 1, -1);
    check("strobe_count_mixed", strobe_cnt, 34);

    // nothing to check: done straight from WAIT_DONE
    run(0, 16'h0000, 5, 0, 2, 6);

    // reset while in RD_WAIT of the first word
    done_delay = 50;
    stall_mode = 0;
    for (int i = 0; i < 16; i++) exp_src_q.push_back(omem[i]);
    send_cmd(2'd2, 10'd7, 16'h00AA, 1'b1, 11'd16);
    end_cmds();
    repeat (53) @(negedge clk);
    check("busy_before_rst", busy, 1);
    rst = 1;
    wr_q.delete();
    start_q.delete();
    addr_q.delete();
    res_q.delete();
    exp_src_q.delete();
    #1;
    check("arst_busy", busy, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_mem_en", mem_en, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_data", mem_data, 0);
    check("arst_ap_start", ap_start, 0);
    check("arst_exp_ready", exp_ready, 0);
    check("arst_addrO", addrO, 0);
    check("arst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // fresh run after the abort
    run(4, 16'h0000, 10, 0, 2, 10 + 1 + 3 * 4);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
